// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: loadable instruction store, PC and run/stall/halt control.
// Presents one registered instruction per cycle, split into op/func for the decoder.
module instr_fetch_unit #(
  parameter int          ADDR_W  = 6,
  parameter int          DATA_W  = 32,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              run,
  input  logic              stall,
  input  logic              jump,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        op,
  output logic [3:0]        func,
  output logic              instr_valid,
  output logic              halted,
  output logic [15:0]       retired
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, next_pc;
  logic [DATA_W-1:0] instr_q, instr_d, first_word;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic [15:0]       retired_q, retired_d;
  logic              mem_we;

  assign mem_we = rst_n && prog_we && (state_q == S_IDLE);

  // Same-cycle write to address 0 must be seen by the very first fetch.
  assign first_word = (prog_we && prog_addr == '0) ? prog_data : mem[0];
  assign next_pc    = jump ? instr_q[ADDR_W-1:0] : pc_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (run) begin
          state_d = S_RUN;
          pc_d    = '0;
          instr_d = first_word;
          valid_d = 1'b1;
        end
      end
      S_RUN, S_HALT: begin
        if (!run) begin
          state_d  = S_IDLE;
          pc_d     = '0;
          instr_d  = '0;
          valid_d  = 1'b0;
          halted_d = 1'b0;
        end else if (state_q == S_RUN && valid_q) begin
          if (instr_q[31:26] == HALT_OP) begin
            state_d  = S_HALT;
            valid_d  = 1'b0;
            halted_d = 1'b1;
          end else if (!stall) begin
            pc_d      = next_pc;
            instr_d   = mem[next_pc];
            retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign func        = instr_q[3:0];
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a behavioural model pushes expected
// outputs per driven cycle; they are popped and compared after the clock edge.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, prog_we, run, stall, jump;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic [5:0]  pc;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [3:0]  func;
  logic        instr_valid, halted;
  logic [15:0] retired;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .run(run), .stall(stall), .jump(jump),
    .pc(pc), .instr(instr), .op(op), .func(func),
    .instr_valid(instr_valid), .halted(halted), .retired(retired)
  );

  typedef struct {
    logic [5:0]  pc;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    logic [15:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  logic [31:0] m [64];
  int          ms;
  logic [5:0]  m_pc;
  logic [31:0] m_instr;
  logic        m_valid, m_halted;
  logic [15:0] m_ret;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic rs, input logic r, input logic st, input logic j,
                       input logic we, input logic [5:0] a, input logic [31:0] d);
    if (!rs) begin
      ms = 0; m_pc = 0; m_instr = 0; m_valid = 0; m_halted = 0; m_ret = 0;
    end else if (ms == 0) begin
      if (we) m[a] = d;
      if (r) begin
        ms = 1; m_pc = 0; m_instr = m[0]; m_valid = 1;
      end
    end else if (!r) begin
      ms = 0; m_pc = 0; m_instr = 0; m_valid = 0; m_halted = 0;
    end else if (ms == 1) begin
      if (m_instr[31:26] == 6'h3F) begin
        ms = 2; m_valid = 0; m_halted = 1;
      end else if (!st) begin
        m_pc    = j ? m_instr[5:0] : m_pc + 6'd1;
        m_instr = m[m_pc];
        if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
      end
    end
  endtask

  task automatic step(input logic rs, input logic r, input logic st, input logic j,
                      input logic we, input logic [5:0] a, input logic [31:0] d);
    exp_t e;
    rst_n = rs; run = r; stall = st; jump = j;
    prog_we = we; prog_addr = a; prog_data = d;
    model(rs, r, st, j, we, a, d);
    e.pc = m_pc; e.instr = m_instr; e.valid = m_valid; e.halted = m_halted; e.ret = m_ret;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("pc", 32'(pc), 32'(e.pc));
    chk("instr", instr, e.instr);
    chk("op", 32'(op), 32'(e.instr[31:26]));
    chk("func", 32'(func), 32'(e.instr[3:0]));
    chk("valid", 32'(instr_valid), 32'(e.valid));
    chk("halted", 32'(halted), 32'(e.halted));
    chk("retired", 32'(retired), 32'(e.ret));
  endtask

  task automatic prog(input logic [5:0] a, input logic [31:0] d);
    step(1, 0, 0, 0, 1, a, d);
  endtask

  task automatic idle_cyc(input logic r, input logic st, input logic j);
    step(1, r, st, j, 0, 6'd0, 32'd0);
  endtask

  initial begin
    rst_n = 0; run = 0; stall = 0; jump = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
    @(negedge clk);

    // Reset state
    step(0, 0, 0, 0, 0, 6'd0, 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);

    // Jump loop: decoder jump driven from op==2
    prog(6'd0, 32'h00000000);
    prog(6'd1, 32'h08000001);
    prog(6'd2, 32'h34000003);
    prog(6'd3, 32'hFC000000);
    idle_cyc(1, 0, 0);
    for (int i = 0; i < 8; i++) idle_cyc(1, 0, (m_instr[31:26] == 6'b000010));
    chk("loop_pc", 32'(pc), 32'd1);
    chk("loop_ret", 32'(retired), 32'd8);
    idle_cyc(0, 0, 0);

    // Halt at pc 2
    step(0, 0, 0, 0, 0, 6'd0, 32'd0);
    prog(6'd0, 32'h0);
    prog(6'd1, 32'h0);
    prog(6'd2, 32'hFC000000);
    for (int i = 0; i < 6; i++) idle_cyc(1, 0, 0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", 32'(pc), 32'd2);
    chk("halt_ret", 32'(retired), 32'd2);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    idle_cyc(1, 1, 1);

    // Stall with jump asserted is ignored
    idle_cyc(0, 0, 0);
    step(0, 0, 0, 0, 0, 6'd0, 32'd0);
    prog(6'd2, 32'h0);
    idle_cyc(1, 0, 0);
    idle_cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) idle_cyc(1, 1, 1);
    chk("stall_pc", 32'(pc), 32'd1);
    idle_cyc(1, 0, 0);
    chk("release_pc", 32'(pc), 32'd2);
    idle_cyc(0, 0, 0);

    // Wrap and ignored write while running
    for (int i = 0; i < 64; i++) prog(6'(i), 32'h0);
    step(0, 0, 0, 0, 0, 6'd0, 32'd0);
    idle_cyc(1, 0, 0);
    step(1, 1, 0, 0, 1, 6'd5, 32'hFC000000);
    for (int i = 0; i < 70; i++) idle_cyc(1, 0, 0);
    chk("wrap_pc", 32'(pc), 32'd7);
    chk("wrap_nohalt", 32'(halted), 32'd0);

    // Mid-run reset at pc 7
    step(0, 1, 0, 0, 0, 6'd0, 32'd0);
    chk("mrst_pc", 32'(pc), 32'd0);
    chk("mrst_ret", 32'(retired), 32'd0);
    prog(6'd1, 32'hFC000000);
    for (int i = 0; i < 4; i++) idle_cyc(1, 0, 0);
    chk("h2_halted", 32'(halted), 32'd1);
    idle_cyc(0, 0, 0);
    chk("h2_idle_halted", 32'(halted), 32'd0);
    chk("h2_ret_held", 32'(retired), 32'd1);

    // Same-cycle write to address 0 and run
    step(1, 1, 0, 0, 1, 6'd0, 32'h8C000005);
    chk("first_op", 32'(op), 32'h23);
    chk("first_func", 32'(func), 32'h5);
    idle_cyc(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
